// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame constants and common scan codes.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HIGH,
      ST_LOW,
      ST_GAP
   } ps2_tx_state_t;

   localparam int   PS2_FRAME_BITS = 11;
   localparam logic PS2_START      = 1'b0;
   localparam logic PS2_STOP       = 1'b1;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   // PS/2 parity makes the total count of ones across data plus parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~(^data);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous reset, full/empty flags and count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset so it can map onto distributed or block RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: buffers scan-code bytes and serializes each
// as an 11-bit frame on the device-driven ps2_clk/ps2_data pair.
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy
);

   localparam int PW = $clog2(2 * CLK_DIV);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] GAP_LAST   = PW'(2 * CLK_DIV - 1);
   localparam logic [3:0]    LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

   ps2_tx_state_t   state;
   logic [PW-1:0]   phase;
   logic [3:0]      bit_cnt;
   logic [10:0]     shift_reg;

   logic            push;
   logic            pop;
   logic [7:0]      fifo_data;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_next;
   logic [10:0]     frame;

   assign in_ready   = !fifo_full && !rst;
   assign push       = in_valid && in_ready;
   assign pop        = (state == ST_LOAD);
   assign count_next = fifo_count + CW'(push) - CW'(pop);
   assign frame      = {PS2_STOP, odd_parity(fifo_data), fifo_data, PS2_START};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The shift register holds the bits still to be sent; ps2_data is the bit on the wire,
   // so each advance moves the register LSB onto the line and back-fills with idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         phase     <= '0;
         bit_cnt   <= '0;
         shift_reg <= '1;
         ps2_clk   <= 1'b1;
         ps2_data  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               phase <= '0;
               if (!fifo_empty) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
               end else begin
                  busy  <= push;
               end
            end

            ST_LOAD: begin
               shift_reg <= {1'b1, frame[10:1]};
               ps2_data  <= frame[0];
               ps2_clk   <= 1'b1;
               bit_cnt   <= '0;
               phase     <= '0;
               busy      <= 1'b1;
               state     <= ST_HIGH;
            end

            ST_HIGH: begin
               if (phase == PHASE_LAST) begin
                  phase   <= '0;
                  ps2_clk <= 1'b0;
                  state   <= ST_LOW;
               end else begin
                  phase   <= phase + 1'b1;
               end
            end

            ST_LOW: begin
               if (phase == PHASE_LAST) begin
                  phase   <= '0;
                  ps2_clk <= 1'b1;
                  if (bit_cnt < LAST_BIT) begin
                     bit_cnt               <= bit_cnt + 1'b1;
                     {shift_reg, ps2_data} <= {1'b1, shift_reg};
                     state                 <= ST_HIGH;
                  end else begin
                     ps2_data <= 1'b1;
                     state    <= ST_GAP;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            ST_GAP: begin
               if (phase == GAP_LAST) begin
                  phase <= '0;
                  state <= ST_IDLE;
                  busy  <= (count_next != '0);
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: accepted bytes queue their hand-computed expectations,
// and a PS/2 receiver model decodes frames on ps2_clk falling edges and checks them.
module tb_ps2_kbd_tx;
   import ps2_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int CLK_PER = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   exp_t        exp_q[$];
   time         fall_times[$];
   time         last_acc;
   int          vectors = 0;
   int          miscompares = 0;
   int          frames_rx = 0;
   int          stable_errs = 0;
   logic [10:0] last_frame = '0;

   ps2_kbd_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .busy     (busy)
   );

   always #(CLK_PER / 2) clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic failNote(input string name, input string what);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got %s, required completion", name, what);
   endtask

   // Presents a byte at a falling clk edge and holds it until accepted; the expectation is
   // queued only when the handshake completes.
   task automatic applyStimulus(input logic [7:0] d, input logic p, output int waits);
      logic ok;
      waits    = 0;
      in_data  = d;
      in_valid = 1'b1;
      forever begin
         ok = in_ready;
         @(posedge clk);
         if (ok) begin
            last_acc = $time;
            exp_q.push_back('{data: d, par: p});
            break;
         end
         @(negedge clk);
         waits++;
         if (waits > 2000) begin
            failNote("accept_timeout", "no in_ready");
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) failNote("idle_wait", "timeout");
   endtask

   // Receiver model: samples ps2_data on every ps2_clk falling edge, drops partial frames on reset.
   initial begin
      logic [10:0] fr;
      int          nb;
      exp_t        e;
      fr = '0;
      nb = 0;
      forever begin
         @(negedge ps2_clk or posedge rst);
         if (rst) begin
            nb = 0;
         end else begin
            if (nb == 0) fall_times.push_back($time);
            fr[nb] = ps2_data;
            nb++;
            if (nb == PS2_FRAME_BITS) begin
               nb = 0;
               frames_rx++;
               last_frame = fr;
               checkOutput("rx_start_bit", 32'(fr[0]), 32'(PS2_START));
               checkOutput("rx_stop_bit", 32'(fr[10]), 32'(PS2_STOP));
               if (exp_q.size() == 0) begin
                  failNote("rx_unexpected_frame", $sformatf("byte %0h", fr[8:1]));
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("rx_data", 32'(fr[8:1]), 32'(e.data));
                  checkOutput("rx_parity", 32'(fr[9]), 32'(e.par));
               end
            end
         end
      end
   end

   // ps2_data must not move while ps2_clk is held low.
   initial begin
      logic pc;
      logic pd;
      pc = 1'b1;
      pd = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && !ps2_clk && !pc && ps2_data !== pd) stable_errs++;
         pc = ps2_clk;
         pd = ps2_data;
      end
   end

   initial begin
      #(CLK_PER * 60000);
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] burst [10];
      logic       bpar  [10];
      int         w;
      int         n;
      int         f0;
      int         low_cnt;
      int         first_wait_idx;
      time        t0;

      burst = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, PS2_EXT};
      bpar  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};

      repeat (3) @(negedge clk);
      checkOutput("rst_ps2_clk", 32'(ps2_clk), 1);
      checkOutput("rst_ps2_data", 32'(ps2_data), 1);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_in_ready", 32'(in_ready), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_rst", 32'(in_ready), 1);

      $display("[TB] single byte 1C");
      fall_times.delete();
      applyStimulus(8'h1C, 1'b0, w);
      t0 = last_acc;
      checkOutput("busy_rise", 32'(busy), 1);
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("busy_fall_cycle", n, 98);
      checkOutput("frame_1C_bits", 32'(last_frame), 32'(11'b10000111000));
      if (fall_times.size() > 0)
         checkOutput("first_fall_latency", 32'((fall_times[0] - t0) / CLK_PER), CLK_DIV + 2);
      else
         failNote("first_fall_latency", "no falling edge");

      $display("[TB] back-to-back F0 1C");
      fall_times.delete();
      applyStimulus(PS2_BREAK, 1'b1, w);
      applyStimulus(8'h1C, 1'b0, w);
      waitIdle(600);
      if (fall_times.size() >= 2)
         checkOutput("frame_period", 32'((fall_times[1] - fall_times[0]) / CLK_PER), 24 * CLK_DIV + 2);
      else
         failNote("frame_period", "fewer than two frames");

      $display("[TB] bytes 00 FF");
      stable_errs = 0;
      applyStimulus(8'h00, 1'b1, w);
      applyStimulus(8'hFF, 1'b1, w);
      waitIdle(600);
      checkOutput("data_stable_low", stable_errs, 0);

      $display("[TB] burst of 10");
      f0 = frames_rx;
      first_wait_idx = -1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(burst[i], bpar[i], w);
         if (w > 0 && first_wait_idx < 0) first_wait_idx = i;
      end
      checkOutput("first_stall_index", 32'(first_wait_idx), 9);
      waitIdle(3000);
      checkOutput("burst_frames", frames_rx - f0, 10);

      $display("[TB] reset during A5");
      f0 = frames_rx;
      applyStimulus(8'hA5, 1'b1, w);
      applyStimulus(8'h11, 1'b1, w);
      applyStimulus(8'h22, 1'b1, w);
      applyStimulus(8'h33, 1'b1, w);
      repeat (41) @(negedge clk);
      checkOutput("busy_mid_frame", 32'(busy), 1);
      checkOutput("frames_before_rst", frames_rx - f0, 0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      checkOutput("abort_ps2_clk", 32'(ps2_clk), 1);
      checkOutput("abort_ps2_data", 32'(ps2_data), 1);
      checkOutput("abort_busy", 32'(busy), 0);
      rst = 1'b0;
      f0 = frames_rx;
      low_cnt = 0;
      repeat (300) begin
         @(negedge clk);
         if (!ps2_clk) low_cnt++;
      end
      checkOutput("no_frames_after_rst", frames_rx - f0, 0);
      checkOutput("clk_idle_after_rst", low_cnt, 0);
      checkOutput("busy_after_rst", 32'(busy), 0);
      applyStimulus(8'h3C, 1'b1, w);
      waitIdle(600);
      checkOutput("frame_after_rst", frames_rx - f0, 1);

      $display("[TB] valid during reset");
      f0 = frames_rx;
      rst      = 1'b1;
      in_data  = 8'h55;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("in_ready_during_rst", 32'(in_ready), 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      low_cnt = 0;
      repeat (200) begin
         @(negedge clk);
         if (!ps2_clk) low_cnt++;
      end
      checkOutput("no_frame_from_rst_valid", frames_rx - f0, 0);
      checkOutput("clk_idle_rst_valid", low_cnt, 0);
      checkOutput("busy_rst_valid", 32'(busy), 0);
      checkOutput("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 keyboard transmitter, the sending end of the board's PS/2 keyboard input. It accepts scan-code bytes over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as an 11-bit PS/2 frame on the device-driven `ps2_clk`/`ps2_data` pair. The block is used as a keyboard stand-in on the simulation bench and as a loopback source feeding the top-level `ps2_clk`/`ps2_data` inputs.

## Interface
- `CLK_DIV`, 4: half-period of `ps2_clk` in `clk` cycles; must be ≥2 (set 2000 for 50 MHz / 12.5 kHz on hardware).
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_data`  in  8  scan-code byte to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a byte. A byte is accepted on an edge where `in_valid && in_ready`.
- `ps2_clk`  out  1  PS/2 clock, idle high.
- `ps2_data`  out  1  PS/2 data, idle high.
- `busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- Frame: start bit 0, then D0..D7 (LSB first), then odd parity (ones in D0..D7 plus parity is odd), then stop bit 1.
- Each bit has two phases:
  - HIGH: `ps2_data` is updated on entry; `ps2_clk`=1 for `CLK_DIV` cycles.
  - LOW: `ps2_clk`=0 for `CLK_DIV` cycles; `ps2_data` is held stable. The receiver samples on the falling edge.
- FSM states: IDLE, LOAD, HIGH, LOW, GAP.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD: pop the FIFO, latch the byte into an 11-bit shift register, compute parity, clear the bit counter. Then go to HIGH.
  - HIGH → LOW when the phase counter reaches `CLK_DIV`-1.
  - LOW → HIGH (next bit) when the phase counter reaches `CLK_DIV`-1 and the bit counter is below 10; LOW → GAP after bit 10.
  - GAP: both lines high for 2·`CLK_DIV` cycles, then → IDLE.
- `in_ready` = !full and !`rst`.
- Push and pop in the same cycle is allowed; the count stays unchanged.
- Back-to-back bytes are sent with exactly the GAP plus the IDLE and LOAD cycles between frames.
- `in_valid` without `in_ready` is ignored; no data is lost inside the block.
- Reset mid-frame aborts the frame:
  - FIFO is flushed.
  - Next cycle: `ps2_clk`=`ps2_data`=1, state IDLE.
  - No partial-frame recovery.

## Timing
- Reset values: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `in_ready`=0 during `rst`, then 1.
- All outputs are registered; no combinational path from `in_valid` to any output.
- Latency, with a byte accepted at edge T into an idle block:
  - FSM enters LOAD at T+1.
  - `ps2_data`=0 (start bit) is visible after edge T+2.
  - First `ps2_clk` falling edge is at T+2+`CLK_DIV`.
- Frame length: 22·`CLK_DIV` cycles from the start-bit HIGH entry to the end of the stop-bit LOW phase.
- Frame period for back-to-back bytes: 24·`CLK_DIV`+2 cycles.
- `busy` rises the cycle after the first accept and falls the cycle after GAP ends with the FIFO empty.
- Parity is computed at LOAD as the complement of the XOR of the 8 data bits.

## Structure
- Shared package `ps2_pkg` holds:
  - the FSM state enum;
  - frame constants: `PS2_FRAME_BITS`=11, `PS2_START`=0, `PS2_STOP`=1;
  - common scan-code constants: `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0.
- One sub-module: `sync_fifo` (width 8, depth `FIFO_DEPTH`, synchronous reset, full/empty flags, count). It is reused later by the receiver-side scan-code buffer.
- The FSM, phase counter, bit counter and shift register live in `ps2_kbd_tx`.

## Test plan
- Reset release then send 8'h1C at `CLK_DIV`=4:
  - line sequence sampled at `ps2_clk` falling edges is 0,0,0,1,1,1,0,0,0,0,1 (parity 0);
  - first falling edge at T+6; `busy` drops at the required cycle.
- Send 8'hF0 then 8'h1C back-to-back:
  - parity 1, then parity 0;
  - second start bit begins exactly 24·`CLK_DIV`+2 cycles after the first;
  - the receiver-model decode is F0, 1C.
- Bytes 8'h00 and 8'hFF: parity is 1 for both; stop bit is 1; `ps2_data` never changes while `ps2_clk`=0.
- Burst of 10 bytes with `in_valid` held high:
  - `in_ready` drops once the FIFO holds 8 and the frame is active;
  - all 10 bytes are received in order, with no duplicates.
- Assert `rst` for 1 cycle during bit 5 of 8'hA5 with 3 bytes queued:
  - next cycle both lines are 1 and `busy`=0;
  - no further frames are sent;
  - a new byte afterwards transmits correctly.
- `in_valid` pulse while `rst`=1: byte is not accepted and no frame appears.
